// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: request/flush from pipeline control, instruction
// memory read port, and the valid/ready handshake towards decode.
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] i_raddr;
    logic [15:0]           i_rdata;
    logic [31:0]           instr;
    logic                  instr_len;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  busy;

    // Requester side: pipeline control, instruction memory and decode.
    modport master (
        output start, pc_in, flush, i_rdata, instr_ready,
        input  i_raddr, instr, instr_len, next_pc, instr_valid, busy
    );

    // Fetch sequencer side.
    modport slave (
        input  start, pc_in, flush, i_rdata, instr_ready,
        output i_raddr, instr, instr_len, next_pc, instr_valid, busy
    );
endinterface

// File: rtl/fetch_ctrl.sv
// AAP variable-length instruction fetch sequencer. Reads the first word,
// uses bit 15 to pick 16- or 32-bit length, optionally reads the second
// word, then presents the assembled instruction over valid/ready.
// The second-word read is issued speculatively so a 32-bit fetch costs
// only one extra cycle over a 16-bit one.
module fetch_ctrl #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD1   = 3'd1,
        S_W1    = 3'd2,
        S_W2    = 3'd3,
        S_VALID = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  len_q, len_d;
    logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
    logic                  valid_q, valid_d;

    logic                  abort;
    logic                  take_start;

    // flush only matters once a fetch is in flight; a start that coincides
    // with flush is dropped so the requester must reassert it.
    assign abort      = bus.flush && (state_q != S_IDLE);
    assign take_start = bus.start && !bus.flush &&
                        ((state_q == S_IDLE) ||
                         ((state_q == S_VALID) && bus.instr_ready));

    // State and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            raddr_q   <= '0;
            instr_q   <= '0;
            len_q     <= 1'b0;
            next_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            raddr_q   <= raddr_d;
            instr_q   <= instr_d;
            len_q     <= len_d;
            next_pc_q <= next_pc_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (take_start) state_d = S_RD1;
                S_RD1:   state_d = S_W1;
                S_W1:    state_d = bus.i_rdata[15] ? S_W2 : S_VALID;
                S_W2:    state_d = S_VALID;
                S_VALID: begin
                    if (bus.instr_ready) state_d = take_start ? S_RD1 : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the address, instruction and handshake registers.
    always_comb begin
        pc_d      = pc_q;
        raddr_d   = raddr_q;
        instr_d   = instr_q;
        len_d     = len_q;
        next_pc_d = next_pc_q;
        valid_d   = valid_q;
        if (abort) begin
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (take_start) begin
                        pc_d    = bus.pc_in;
                        raddr_d = bus.pc_in;
                    end
                end
                S_RD1: begin
                    raddr_d = pc_q + ADDR_WIDTH'(1);
                end
                S_W1: begin
                    instr_d[31:16] = bus.i_rdata;
                    if (!bus.i_rdata[15]) begin
                        instr_d[15:0] = 16'h0000;
                        len_d         = 1'b0;
                        next_pc_d     = pc_q + ADDR_WIDTH'(1);
                        valid_d       = 1'b1;
                    end
                end
                S_W2: begin
                    instr_d[15:0] = bus.i_rdata;
                    len_d         = 1'b1;
                    next_pc_d     = pc_q + ADDR_WIDTH'(2);
                    valid_d       = 1'b1;
                end
                S_VALID: begin
                    if (bus.instr_ready) begin
                        valid_d = 1'b0;
                        if (take_start) begin
                            pc_d    = bus.pc_in;
                            raddr_d = bus.pc_in;
                        end
                    end
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    assign bus.i_raddr     = raddr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_len   = len_q;
    assign bus.next_pc     = next_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for AAP variable-length instruction fetch from the 16-bit-wide instruction memory port. On a start request it reads the first word at the supplied PC and inspects bit 15 to choose length: 0 = 16-bit, 1 = 32-bit. For 32-bit it reads the second word and assembles the instruction, then presents it to decode over a valid/ready handshake. Sits between the pipeline control state machine and the instruction memory, and supports flush/redirect on branches.

Parameters:
ADDR_WIDTH, 24, word-address width of pc, i_raddr, next_pc

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request fetch at pc_in; honoured only in IDLE or on the accept cycle in VALID
pc_in  input  ADDR_WIDTH  word address of instruction to fetch
flush  input  1  abort current fetch/drop presented instruction
i_raddr  output  ADDR_WIDTH  instruction memory read address (registered)
i_rdata  input  16  memory data; value in cycle t is mem[i_raddr of cycle t-1]
instr  output  32  fetched instruction: 16-bit in [31:16] with [15:0]=0; 32-bit first word [31:16], second word [15:0]
instr_len  output  1  0 = 16-bit, 1 = 32-bit; valid with instr_valid
next_pc  output  ADDR_WIDTH  pc + 1 (16-bit) or pc + 2 (32-bit), modulo 2^ADDR_WIDTH
instr_valid  output  1  instr/instr_len/next_pc valid
instr_ready  input  1  decode accepts when instr_valid & instr_ready at posedge
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at posedge): state IDLE; instr=0, instr_len=0, next_pc=0, i_raddr=0, instr_valid=0, busy=0. Reset overrides flush and start, including mid-fetch.
- States: IDLE, RD1, W1, W2, VALID. All outputs registered.
- IDLE: if start, latch pc=pc_in, i_raddr<=pc_in, go RD1; else stay.
- RD1: i_raddr<=pc+1 (speculative second-word read), go W1.
- W1: i_rdata = mem[pc]; instr[31:16]<=i_rdata.
  - If i_rdata[15]=0: instr[15:0]<=0, instr_len<=0, next_pc<=pc+1, instr_valid<=1, go VALID.
  - Else go W2.
- W2: i_rdata = mem[pc+1]; instr[15:0]<=i_rdata, instr_len<=1, next_pc<=pc+2, instr_valid<=1, go VALID.
- Latency, start sampled at cycle 0: 16-bit instr_valid high from cycle 3; 32-bit from cycle 4.
- VALID: instr, instr_len and next_pc held stable while instr_ready=0.
  - If instr_ready and start: instr_valid<=0, latch new pc_in, i_raddr<=pc_in, go RD1 (back-to-back).
  - If instr_ready only: instr_valid<=0, go IDLE.
- start outside IDLE, and outside the accept cycle in VALID, is ignored (not queued).
- flush (any non-IDLE state): next cycle state IDLE, instr_valid=0. instr and i_raddr keep their values. Any memory data arriving afterwards is discarded. flush in IDLE has no effect.
- Priority: rst > flush > start. start with flush in the same cycle is ignored; requester must reassert.
- Address arithmetic is ADDR_WIDTH-bit unsigned with wrap: pc=0xFFFFFF gives second read at 0x000000, next_pc 0x000000 (16-bit) or 0x000001 (32-bit).
- i_raddr changes only on IDLE->RD1, in RD1, and on the VALID accept-with-start transition; otherwise held.

Test Plan:
- Reset: assert rst for 2 cycles mid-32-bit fetch (state W1) -> next cycle all outputs 0, state IDLE, busy=0; no instr_valid afterwards.
- 16-bit fetch: mem[0x000010]=0x1234, start with pc_in=0x000010 at cycle 0 -> i_raddr 0x10 then 0x11; cycle 3 instr_valid=1, instr=0x12340000, instr_len=0, next_pc=0x000011.
- 32-bit fetch with backpressure: mem[0x20]=0x8001, mem[0x21]=0xBEEF, instr_ready=0 for 3 cycles -> valid from cycle 4, instr=0x8001BEEF, instr_len=1, next_pc=0x22, held stable until ready; valid drops cycle after accept.
- Back-to-back and wrap: accept with start, pc_in=0xFFFFFF, mem[0xFFFFFF]=0x8000, mem[0x0]=0x0042 -> RD1 immediately after accept; instr=0x80000042, next_pc=0x000001.
- Flush: flush asserted in W1 of a 32-bit fetch -> IDLE next cycle, instr_valid never asserts. Start with flush in the same cycle ignored; start the following cycle fetches normally.
- Ignored start: start pulsed in RD1/W1/W2 with a different pc_in -> current fetch completes with original pc; no second fetch occurs.
